// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronizes columns, scans rows on a divided tick,
// debounces press and release. Define KEYPAD_MULTI_KEY_REJECT_EN to ignore multi-key samples.
module keypad_scanner #(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_TICKS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       start,
   output logic       clear
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEB_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SCAN     = 3'd1;
   localparam logic [2:0] S_DEBOUNCE = 3'd2;
   localparam logic [2:0] S_PRESSED  = 3'd3;
   localparam logic [2:0] S_RELEASE  = 3'd4;

   localparam logic [3:0] CODE_STAR = 4'hE;
   localparam logic [3:0] CODE_HASH = 4'hF;

   logic [2:0]    state;
   logic [1:0]    idx;
   logic [1:0]    lcol;
   logic [DW-1:0] deb;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    col_meta;
   logic [3:0]    col_sync;
   logic          any_low;
   logic          lcol_high;
   logic          reject;
   logic [3:0]    hit_code;

   function automatic logic [1:0] low_col(input logic [3:0] c);
      logic [1:0] r;
      r = 2'd0;
      if (!c[0])      r = 2'd0;
      else if (!c[1]) r = 2'd1;
      else if (!c[2]) r = 2'd2;
      else if (!c[3]) r = 2'd3;
      return r;
   endfunction

   function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = CODE_STAR;
         4'b11_01: k = 4'h0;
         4'b11_10: k = CODE_HASH;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   // Columns are asynchronous to clk; all decisions use col_sync only.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         col_meta <= '1;
         col_sync <= '1;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n)     tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick      = (tick_cnt == TICK_LAST);
   assign any_low   = ~&col_sync;
   assign lcol_high = col_sync[lcol];
   assign hit_code  = map_key(idx, lcol);

`ifdef KEYPAD_MULTI_KEY_REJECT_EN
   always_comb begin
      int unsigned zeros;
      zeros = 0;
      for (int unsigned i = 0; i < 4; i++)
         if (!col_sync[i]) zeros = zeros + 1;
      reject = (zeros >= 2);
   end
`else
   assign reject = 1'b0;
`endif

   always_comb begin
      row = '0;
      if (state != S_IDLE) row = ~(4'b0001 << idx);
   end

   // idx doubles as the scan pointer and, once a hit is latched, the driven row.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         lcol      <= '0;
         deb       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         start     <= 1'b0;
         clear     <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         start     <= 1'b0;
         clear     <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (any_low) begin
                     state <= S_SCAN;
                     idx   <= '0;
                  end
               end
               S_SCAN: begin
                  if (reject) begin
                     state <= S_IDLE;
                  end else if (any_low) begin
                     lcol  <= low_col(col_sync);
                     deb   <= '0;
                     state <= S_DEBOUNCE;
                  end else if (idx == 2'd3) begin
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               S_DEBOUNCE: begin
                  if (reject || lcol_high) begin
                     state <= S_IDLE;
                  end else if (deb == DEB_LAST) begin
                     deb       <= deb + 1'b1;
                     state     <= S_PRESSED;
                     key_code  <= hit_code;
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     start     <= (hit_code == CODE_HASH);
                     clear     <= (hit_code == CODE_STAR);
                  end else begin
                     deb <= deb + 1'b1;
                  end
               end
               S_PRESSED: begin
                  if (lcol_high) begin
                     deb   <= '0;
                     state <= S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  if (!lcol_high) begin
                     state <= S_PRESSED;
                  end else if (deb == DEB_LAST) begin
                     deb      <= deb + 1'b1;
                     state    <= S_IDLE;
                     key_held <= 1'b0;
                  end else begin
                     deb <= deb + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEB_TICKS=3).
// Honors KEYPAD_MULTI_KEY_REJECT_EN for the two-key step.
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_TICKS = 3;

   logic       clk;
   logic       rst_n;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       start;
   logic       clear;

   logic [15:0] keys;      // bit r*4+c set = key (r,c) physically closed
   int unsigned vectors;
   int unsigned miscompares;
   int unsigned valid_cnt;
   int unsigned start_cnt;
   int unsigned clear_cnt;
   int unsigned orphan_cnt;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .col      (col),
      .row      (row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held),
      .start    (start),
      .clear    (clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      col = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
   end

   // Strobes are one cycle wide, so one falling edge sees each pulse once.
   always @(negedge clk) begin
      if (key_valid) valid_cnt++;
      if (start) start_cnt++;
      if (clear) clear_cnt++;
      if ((start || clear) && !key_valid) orphan_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * SCAN_DIV) @(negedge clk);
   endtask

   initial begin
      int unsigned base;
      int unsigned waited;
      vectors = 0; miscompares = 0;
      valid_cnt = 0; start_cnt = 0; clear_cnt = 0; orphan_cnt = 0;
      keys  = '0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      check("reset_row", 32'(row), 32'h0);
      check("reset_code", 32'(key_code), 32'h0);
      check("reset_flags", 32'({key_valid, key_held, start, clear}), 32'h0);

      rst_n = 1'b0;
      repeat (100) @(negedge clk);
      check("idle_row", 32'(row), 32'h0);
      check("idle_strobes", valid_cnt + start_cnt + clear_cnt, 32'd0);
      check("idle_code", 32'(key_code), 32'h0);

      // Key 5 held for 40 ticks: exactly one acceptance.
      keys[1*4+1] = 1'b1;
      wait_ticks(40);
      check("k5_valid_cnt", valid_cnt, 32'd1);
      check("k5_code", 32'(key_code), 32'h5);
      check("k5_held", 32'(key_held), 32'h1);
      check("k5_start_clear", start_cnt + clear_cnt, 32'd0);

      // One-tick release glitch, then a clean release.
      keys[1*4+1] = 1'b0;
      wait_ticks(1);
      keys[1*4+1] = 1'b1;
      wait_ticks(6);
      check("glitch_valid_cnt", valid_cnt, 32'd1);
      check("glitch_held", 32'(key_held), 32'h1);
      keys[1*4+1] = 1'b0;
      wait_ticks(8);
      check("release_held", 32'(key_held), 32'h0);
      check("release_idle_row", 32'(row), 32'h0);

      // '#' with two-tick bounces before a stable hold.
      for (int b = 0; b < 2; b++) begin
         keys[3*4+2] = 1'b1;
         wait_ticks(2);
         keys[3*4+2] = 1'b0;
         wait_ticks(2);
      end
      check("hash_bounce_no_valid", valid_cnt, 32'd1);
      keys[3*4+2] = 1'b1;
      wait_ticks(40);
      check("hash_valid_cnt", valid_cnt, 32'd2);
      check("hash_code", 32'(key_code), 32'hF);
      check("hash_start_cnt", start_cnt, 32'd1);
      check("hash_clear_cnt", clear_cnt, 32'd0);
      check("start_coincident", orphan_cnt, 32'd0);
      keys[3*4+2] = 1'b0;
      wait_ticks(10);
      check("hash_release_held", 32'(key_held), 32'h0);

      // '*' raises clear, not start.
      keys[3*4+0] = 1'b1;
      wait_ticks(40);
      check("star_code", 32'(key_code), 32'hE);
      check("star_clear_cnt", clear_cnt, 32'd1);
      check("star_start_cnt", start_cnt, 32'd1);
      check("star_coincident", orphan_cnt, 32'd0);
      keys[3*4+0] = 1'b0;
      wait_ticks(10);

      // Two keys on row 0 at once.
      base = valid_cnt;
      keys[0*4+0] = 1'b1;
      keys[0*4+3] = 1'b1;
      wait_ticks(40);
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
      check("multi_rejected", valid_cnt, base);
      check("multi_not_held", 32'(key_held), 32'h0);
`else
      check("multi_valid_cnt", valid_cnt, base + 1);
      check("multi_code", 32'(key_code), 32'h1);
`endif
      keys = '0;
      wait_ticks(10);
      check("multi_release_held", 32'(key_held), 32'h0);

      // Reset pulse during debounce of key 9.
      base = valid_cnt;
      keys[2*4+2] = 1'b1;
      waited = 0;
      while (row !== 4'b1011 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("k9_reached_row2", 32'(row), 32'hB);
      wait_ticks(2);
      check("k9_pre_reset_no_valid", valid_cnt, base);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      check("k9_reset_code", 32'(key_code), 32'h0);
      check("k9_reset_row", 32'(row), 32'h0);
      wait_ticks(3);
      check("k9_fresh_debounce_pending", valid_cnt, base);
      wait_ticks(37);
      check("k9_valid_cnt", valid_cnt, base + 1);
      check("k9_code", 32'(key_code), 32'h9);
      check("k9_held", 32'(key_held), 32'h1);
      keys = '0;
      wait_ticks(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per scan tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DEB_TICKS, default 20, consecutive stable ticks for press/release acceptance.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-high despite the name.
REQ-005 SHALL have port col  input  4  matrix columns, active-low, asynchronous to clk.
REQ-006 SHALL have port row  output  4  matrix row drive, active-low.
REQ-007 SHALL have port key_code  output  4  last accepted key code, held until next acceptance.
REQ-008 SHALL have port key_valid  output  1  one-cycle strobe on press acceptance.
REQ-009 SHALL have port key_held  output  1  high from acceptance until release accepted.
REQ-010 SHALL have port start  output  1  one-cycle strobe, asserted with key_valid when code is 0xF ('#').
REQ-011 SHALL have port clear  output  1  one-cycle strobe, asserted with key_valid when code is 0xE ('*').

Function
REQ-012 col SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Tick counter SHALL count 0..SCAN_DIV-1, wrap to 0, assert internal tick for one cycle at SCAN_DIV-1.
REQ-014 FSM states: IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE; transitions evaluated only on tick, except REQ-019.
REQ-015 IDLE: row=4'b0000; on tick with any col bit low -> SCAN, row index=0.
REQ-016 SCAN: drive only row[index] low; on each tick sample col; if a col bit low, latch (index, lowest low col) -> DEBOUNCE, deb count=0; else index+1; after index 3 with no hit -> IDLE.
REQ-017 DEBOUNCE: keep latched row driven; tick with latched col still low increments count; tick with it high -> IDLE; count reaching DEB_TICKS -> PRESSED.
REQ-018 Key map (row,col)->code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E('*'),0,F('#'),D.
REQ-019 Entry to PRESSED SHALL, in the same cycle, load key_code, pulse key_valid, set key_held, and pulse start/clear per REQ-010/011.
REQ-020 PRESSED: latched row driven; tick with latched col high -> RELEASE, count=0; no repeat strobes while held.
REQ-021 RELEASE: tick with col high increments count; tick with col low returns to PRESSED without strobe; count reaching DEB_TICKS -> IDLE, key_held cleared.
REQ-022 Second key pressed while PRESSED SHALL be ignored until release completes.
REQ-023 Debounce counter width SHALL be clog2(DEB_TICKS+1); tick counter width clog2(SCAN_DIV).

Reset
REQ-024 rst_n high at a clk edge SHALL force: state IDLE, row=4'b0000, key_code=0, key_valid=0, key_held=0, start=0, clear=0, counters 0, synchronizer flops 4'b1111.
REQ-025 rst_n asserted mid-press SHALL abort without strobe; after deassert a still-held key is rescanned and debounced from zero.

Configuration
REQ-026 Macro KEYPAD_MULTI_KEY_REJECT_EN: when defined, a SCAN/DEBOUNCE sample with two or more col bits low -> IDLE with no acceptance; when undefined, lowest-index low column wins per REQ-016.

Verification (SCAN_DIV=4, DEB_TICKS=3)
REQ-027 Reset then idle col=4'hF for 100 cycles -> row=0, all strobes 0, key_code=0.
REQ-028 Hold key (r1,c1) for 40 ticks -> exactly one key_valid, key_code=5, key_held=1, start=0, clear=0.
REQ-029 Key (r3,c2) with 2-tick bounces before stable hold -> single key_valid, key_code=0xF, start pulses once coincident with key_valid.
REQ-030 Release glitch of 1 tick during PRESSED -> no second key_valid; release stable 3 ticks -> key_held=0, state IDLE.
REQ-031 Keys (r0,c0)+(r0,c3) together -> with macro: no key_valid; without: key_valid, key_code=1.
REQ-032 rst_n pulsed 1 cycle during DEBOUNCE of key 9 -> no strobe; key still held -> key_valid with key_code=9 after fresh debounce.
